// File: rtl/pri_req_capture_pkg.sv
// Shared constants and index-code layout for the request-capture stage and the
// 16-bit highest-set-bit priority encoder it feeds.
package pri_req_capture_pkg;

  localparam int         REQ_WIDTH    = 16;
  localparam logic [7:0] REQ_IDX_NONE = 8'hF0;

  // Encoder index code: a zero tag marks a real bit number in bit_idx.
  typedef struct packed {
    logic [3:0] tag;
    logic [3:0] bit_idx;
  } idx_code_t;

  function automatic logic idx_code_valid(input idx_code_t code);
    return code.tag == 4'h0;
  endfunction

endpackage

// File: rtl/pri_req_sync_edge.sv
// Vectored multi-flop synchroniser plus history flop; emits a one-cycle pulse
// per bit when the synchronised request goes from 0 to 1.
module pri_req_sync_edge #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  hist_q;

  // NOTE: chain and history reset to 0, so a line already high at reset
  // release is seen as exactly one rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples its pre-edge
      // neighbour and the chain shifts by exactly one flop per clock.
      sync_q[0] <= req_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/pri_req_capture.sv
// Request-capture stage: synchronised edge capture into sticky pending bits,
// masking toward the encoder, index-code acknowledge and overrun accounting.
module pri_req_capture
  import pri_req_capture_pkg::*;
#(
  parameter int         WIDTH       = REQ_WIDTH,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDX_NONE    = REQ_IDX_NONE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] req_in,
  input  logic             mask_wr,
  input  logic [WIDTH-1:0] mask_data,
  input  logic             ack,
  input  logic [7:0]       ack_idx,
  output logic [WIDTH-1:0] pending_out,
  output logic             irq,
  output logic             ovf,
  output logic [7:0]       drop_cnt,
  input  logic             ovf_clr
);

  localparam int         CNT_W    = $clog2(WIDTH + 1);
  localparam logic [7:0] DROP_MAX = 8'hFF;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] ack_vec;
  logic [WIDTH-1:0] overrun;
  logic [CNT_W-1:0] lost;
  idx_code_t        ack_code;
  logic             ack_ok;

  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_q, drop_d;
  logic [7:0]       drop_base;
  logic [8:0]       drop_sum;

  pri_req_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_in),
    .rise_o(rise)
  );

  assign ack_code = idx_code_t'(ack_idx);
  assign ack_ok   = ack && idx_code_valid(ack_code) && (ack_idx != IDX_NONE);

  // History keeps running while disabled, so only the capture is gated here.
  assign capture = rise & {WIDTH{ena}};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    ack_vec = '0;
    if (ack_ok) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (int'(ack_code.bit_idx) == i) ack_vec[i] = 1'b1;
      end
    end
  end

  // A same-cycle ack of the captured bit absorbs the event, so it is not lost.
  assign overrun   = capture & pending_q & ~ack_vec;
  assign lost      = popcount(overrun);
  assign pending_d = (pending_q & ~ack_vec) | capture;
  assign mask_d    = mask_wr ? mask_data : mask_q;

  always_comb begin
    drop_base = ovf_clr ? 8'h00 : drop_q;
    drop_sum  = {1'b0, drop_base} + 9'(lost);
    drop_d    = drop_sum[8] ? DROP_MAX : drop_sum[7:0];
    ovf_d     = (ovf_q & ~ovf_clr) | (|overrun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      mask_q    <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= 8'h00;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
    end
  end

  assign pending_out = pending_q & ~mask_q;
  assign irq         = |pending_out;
  assign ovf         = ovf_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_pri_req_capture.sv
// Directed bench for pri_req_capture with hand-computed expected values.
module tb_pri_req_capture;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [15:0] req_in;
  logic        mask_wr;
  logic [15:0] mask_data;
  logic        ack;
  logic [7:0]  ack_idx;
  logic [15:0] pending_out;
  logic        irq;
  logic        ovf;
  logic [7:0]  drop_cnt;
  logic        ovf_clr;

  int n_cmp = 0;
  int n_err = 0;

  pri_req_capture #(
    .WIDTH      (16),
    .SYNC_STAGES(2),
    .IDX_NONE   (8'hF0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .req_in     (req_in),
    .mask_wr    (mask_wr),
    .mask_data  (mask_data),
    .ack        (ack),
    .ack_idx    (ack_idx),
    .pending_out(pending_out),
    .irq        (irq),
    .ovf        (ovf),
    .drop_cnt   (drop_cnt),
    .ovf_clr    (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse(input logic [7:0] code);
    ack     = 1'b1;
    ack_idx = code;
    tick();
    ack     = 1'b0;
    ack_idx = 8'h00;
  endtask

  // Raise the given lines long enough to be captured, then drop and let the
  // synchroniser and history settle low again.
  task automatic pulse(input logic [15:0] m);
    req_in = req_in | m;
    repeat (3) tick();
    req_in = req_in & ~m;
    repeat (3) tick();
  endtask

  task automatic check_all(input string tag, input logic [15:0] p, input logic i,
                           input logic o, input logic [7:0] d);
    check({tag, ".pending"}, 32'(pending_out), 32'(p));
    check({tag, ".irq"},     32'(irq),         32'(i));
    check({tag, ".ovf"},     32'(ovf),         32'(o));
    check({tag, ".drop"},    32'(drop_cnt),    32'(d));
  endtask

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b1;
    req_in    = 16'h0000;
    mask_wr   = 1'b0;
    mask_data = 16'h0000;
    ack       = 1'b0;
    ack_idx   = 8'h00;
    ovf_clr   = 1'b0;

    #12;
    check_all("reset", 16'h0000, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Latency: captured on the third edge after the request rises.
    req_in = 16'h0001;
    tick();
    tick();
    check("lat.edge2", 32'(pending_out), 32'h0000);
    tick();
    check("lat.edge3", 32'(pending_out), 32'h0001);
    check("lat.irq", 32'(irq), 32'h1);
    ack_pulse(8'h00);
    check("ack0.pending", 32'(pending_out), 32'h0000);
    check("ack0.irq", 32'(irq), 32'h0);

    // Invalid index codes are ignored; a valid one clears its bit.
    req_in = 16'h1009;
    repeat (3) tick();
    check("b3b12", 32'(pending_out), 32'h1008);
    ack_pulse(8'hF0);
    check("ackF0", 32'(pending_out), 32'h1008);
    ack_pulse(8'h13);
    check("ack13", 32'(pending_out), 32'h1008);
    ack_pulse(8'h0C);
    check("ack0C", 32'(pending_out), 32'h0008);
    req_in = 16'h0000;
    repeat (3) tick();

    // Single overrun, clear, then a counted burst and saturation.
    pulse(16'h0020);
    check_all("first5", 16'h0028, 1'b1, 1'b0, 8'd0);
    pulse(16'h0020);
    check_all("ovr5", 16'h0028, 1'b1, 1'b1, 8'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr.ovf", 32'(ovf), 32'h0);
    check("clr.drop", 32'(drop_cnt), 32'd0);
    for (int k = 0; k < 20; k++) begin
      req_in[5] = ~req_in[5];
      tick();
    end
    repeat (3) tick();
    check("burst10", 32'(drop_cnt), 32'd10);
    for (int k = 0; k < 580; k++) begin
      req_in[5] = ~req_in[5];
      tick();
    end
    repeat (3) tick();
    check("sat.drop", 32'(drop_cnt), 32'd255);
    check("sat.ovf", 32'(ovf), 32'h1);

    // Two bits overrun together while clear is held: overrun wins, count 2.
    req_in  = 16'h0028;
    ovf_clr = 1'b1;
    repeat (3) tick();
    check("clrwin.drop", 32'(drop_cnt), 32'd2);
    check("clrwin.ovf", 32'(ovf), 32'h1);
    ovf_clr = 1'b0;
    req_in  = 16'h0000;
    repeat (3) tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    ack_pulse(8'h03);
    ack_pulse(8'h05);
    check_all("cleaned", 16'h0000, 1'b0, 1'b0, 8'd0);

    // Mask hides a captured bit; unmasking exposes it.
    mask_wr   = 1'b1;
    mask_data = 16'h8000;
    tick();
    mask_wr = 1'b0;
    pulse(16'h8000);
    check("masked.pending", 32'(pending_out), 32'h0000);
    check("masked.irq", 32'(irq), 32'h0);
    mask_wr   = 1'b1;
    mask_data = 16'h0000;
    tick();
    mask_wr = 1'b0;
    check("unmask.pending", 32'(pending_out), 32'h8000);
    check("unmask.irq", 32'(irq), 32'h1);
    ack_pulse(8'h0F);
    check("ack15", 32'(pending_out), 32'h0000);

    // Disabled capture, and no spurious edge when re-enabled on a high line.
    ena = 1'b0;
    pulse(16'h0080);
    check("dis.pulse", 32'(pending_out), 32'h0000);
    req_in = 16'h0080;
    repeat (4) tick();
    ena = 1'b1;
    repeat (4) tick();
    check("reena.high", 32'(pending_out), 32'h0000);
    req_in = 16'h0000;
    repeat (3) tick();

    // Capture and ack of the same bit in the same cycle: capture wins.
    pulse(16'h0004);
    check("b2", 32'(pending_out), 32'h0004);
    req_in = 16'h0004;
    tick();
    tick();
    ack_pulse(8'h02);
    check("same.pending", 32'(pending_out), 32'h0004);
    check("same.ovf", 32'(ovf), 32'h0);
    req_in = 16'h0000;
    repeat (3) tick();
    pulse(16'h0004);
    check_all("prerst", 16'h0004, 1'b1, 1'b1, 8'd1);

    // Asynchronous reset mid-cycle, with a line held high across release.
    @(posedge clk);
    #3;
    rst_n  = 1'b0;
    req_in = 16'h0010;
    #1;
    check_all("asyncrst", 16'h0000, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("relhigh.edge2", 32'(pending_out), 32'h0000);
    tick();
    check("relhigh.edge3", 32'(pending_out), 32'h0010);
    repeat (4) tick();
    check("relhigh.once", 32'(drop_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
